// File: rtl/norm_shifter.sv
`default_nettype none
// ============================================================================
// Module      : norm_shifter
// Description : Sequential normalizer. Shifts a word one bit per cycle until
//               its first set bit reaches the MSB (left) or LSB (right), then
//               reports the normalized word and the shift amount. Handshakes
//               are valid/ready on both sides.
// Revision    : 1.0 - initial release
// ============================================================================
module norm_shifter #(
    parameter  int WIDTH = 8,
    localparam int AMT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_dir,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [AMT_W-1:0] out_amt,
    output logic             out_dir,
    output logic             out_zero
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    localparam logic [AMT_W-1:0] c_one = AMT_W'(1);

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_sreg;
    logic [AMT_W-1:0] r_cnt;
    logic             r_dir;
    logic             r_zero;

    logic             w_in_zero;
    logic             w_in_hit;
    logic [WIDTH-1:0] w_shifted;
    logic             w_sh_hit;

    // Target-bit detection for a freshly accepted word and for the next shift step
    always_comb begin
        w_in_zero = (in_data == '0);
        w_in_hit  = in_dir ? in_data[0] : in_data[WIDTH-1];
        w_shifted = r_dir ? (r_sreg >> 1) : (r_sreg << 1);
        w_sh_hit  = r_dir ? w_shifted[0] : w_shifted[WIDTH-1];
    end

    // Control FSM and datapath registers; results are held until consumed
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_sreg  <= '0;
            r_cnt   <= '0;
            r_dir   <= 1'b0;
            r_zero  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_sreg <= in_data;
                        r_cnt  <= '0;
                        r_dir  <= in_dir;
                        if (w_in_zero) begin
                            r_zero  <= 1'b1;
                            r_state <= S_DONE;
                        end else if (w_in_hit) begin
                            r_state <= S_DONE;
                        end else begin
                            r_state <= S_SHIFT;
                        end
                    end
                end
                S_SHIFT: begin
                    // A nonzero word reaches its target within WIDTH-1 steps,
                    // so the counter cannot overflow here.
                    r_sreg <= w_shifted;
                    r_cnt  <= r_cnt + c_one;
                    if (w_sh_hit) begin
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_zero  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Handshake flags come straight from state; outputs straight from registers
    always_comb begin
        in_ready  = (r_state == S_IDLE);
        out_valid = (r_state == S_DONE);
        out_data  = r_sreg;
        out_amt   = r_cnt;
        out_dir   = r_dir;
        out_zero  = r_zero;
    end

endmodule
`default_nettype wire

// File: tb/tb_norm_shifter.sv
`default_nettype none
// ============================================================================
// Module      : tb_norm_shifter
// Description : Self-checking bench for norm_shifter (WIDTH=8): directed
//               cases followed by randomized words, directions and stalls.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_norm_shifter;

    localparam int WIDTH = 8;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       in_dir;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic [2:0] out_amt;
    logic       out_dir;
    logic       out_zero;

    int n_vec;
    int n_err;

    norm_shifter #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_dir    (in_dir),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_amt   (out_amt),
        .out_dir   (out_dir),
        .out_zero  (out_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: locate the first set bit from the target end by scanning.
    task automatic model(input logic [7:0] d, input logic dir,
                         output logic [7:0] od, output int amt, output logic z);
        bit found;
        z     = (d == 8'h00);
        amt   = 0;
        found = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            if (!found && d[dir ? i : WIDTH-1-i]) begin
                amt   = i;
                found = 1'b1;
            end
        end
        od = dir ? (d >> amt) : (d << amt);
    endtask

    // One full transaction: accept, measure latency, stall, release.
    // in_valid stays asserted (with junk data after acceptance) until the
    // release edge to show that requests are ignored outside IDLE.
    task automatic do_req(input logic [7:0] d, input logic dir, input int stall);
        logic [7:0] exp_d;
        int         exp_amt;
        logic       exp_z;
        int         lat;
        model(d, dir, exp_d, exp_amt, exp_z);
        check("ready_before", {31'd0, in_ready}, 32'd1);
        in_data   = d;
        in_dir    = dir;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        in_data = 8'($urandom);
        in_dir  = 1'($urandom);
        lat = 0;
        while (!out_valid && lat < WIDTH + 4) begin
            @(negedge clk);
            lat++;
        end
        check("out_valid", {31'd0, out_valid}, 32'd1);
        check("latency", lat, exp_amt);
        check("out_data", {24'd0, out_data}, {24'd0, exp_d});
        check("out_amt", {29'd0, out_amt}, exp_amt);
        check("out_dir", {31'd0, out_dir}, {31'd0, dir});
        check("out_zero", {31'd0, out_zero}, {31'd0, exp_z});
        check("ready_busy", {31'd0, in_ready}, 32'd0);
        if (!exp_z) begin
            check("inv_msb_lsb", {31'd0, dir ? out_data[0] : out_data[7]}, 32'd1);
            check("inv_restore", {24'd0, dir ? (out_data << out_amt) : (out_data >> out_amt)},
                  {24'd0, d});
        end
        for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            check("stall_valid", {31'd0, out_valid}, 32'd1);
            check("stall_data", {24'd0, out_data}, {24'd0, exp_d});
            check("stall_amt", {29'd0, out_amt}, exp_amt);
            check("stall_ready", {31'd0, in_ready}, 32'd0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check("post_valid", {31'd0, out_valid}, 32'd0);
        check("post_ready", {31'd0, in_ready}, 32'd1);
        check("post_zero", {31'd0, out_zero}, 32'd0);
    endtask

    initial begin
        n_vec     = 0;
        n_err     = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        in_dir    = 1'b0;
        out_ready = 1'b0;
        #12;
        check("rst_ready", {31'd0, in_ready}, 32'd1);
        check("rst_valid", {31'd0, out_valid}, 32'd0);
        check("rst_data", {24'd0, out_data}, 32'd0);
        check("rst_amt", {29'd0, out_amt}, 32'd0);
        check("rst_dir", {31'd0, out_dir}, 32'd0);
        check("rst_zero", {31'd0, out_zero}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed cases
        do_req(8'h13, 1'b0, 0);
        do_req(8'h50, 1'b1, 0);
        do_req(8'h80, 1'b0, 0);
        do_req(8'h00, 1'b0, 0);
        do_req(8'h00, 1'b1, 2);
        do_req(8'h01, 1'b0, 5);
        do_req(8'h01, 1'b1, 0);
        do_req(8'h80, 1'b1, 1);

        // Asynchronous reset in the middle of a shift sequence
        in_data  = 8'h01;
        in_dir   = 1'b0;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_valid", {31'd0, out_valid}, 32'd0);
        check("arst_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) begin
            @(negedge clk);
            check("arst_no_result", {31'd0, out_valid}, 32'd0);
        end
        do_req(8'h40, 1'b0, 0);

        // Randomized words, directions and consumer stalls
        for (int t = 0; t < 1000; t++) begin
            do_req(8'($urandom), 1'($urandom), int'($urandom_range(0, 3)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
